pcie_tl_requester: RTL and testbench
====================================

Name: pcie_tl_requester

Overview:
Transaction Layer requester (root-complex side) that turns application read and write commands into single-beat MRd/MWr TLPs toward the DLL. It tracks outstanding non-posted reads by tag and matches returning CplD TLPs from the DLL to those tags. It reports read data, poisoned completions, timeouts and unexpected completions back to the application. It is the initiator counterpart of the endpoint transaction layer and uses the same 128-bit header field layout.

Parameters:
ADDR_WIDTH, 64, command address width; zero-extended into header[63:0]
DATA_WIDTH, 256, single-beat payload width (8 DW)
TLP_HEADER_WIDTH, 128, header bus width
NUM_TAGS, 8, outstanding read slots; tags 0..NUM_TAGS-1, tag[9:8]=0
TIMEOUT_CYCLES, 1024, completion timeout per tag, in clk cycles
REQ_ID, 16'h0100, requester ID driven in header[97:82]

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  application command valid
cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready at posedge
cmd_write  input  1  1=MWr (posted), 0=MRd (non-posted)
cmd_addr  input  ADDR_WIDTH  target address
cmd_data  input  DATA_WIDTH  write payload (ignored for reads)
tx_valid  output  1  TLP valid to DLL
tx_header  output  TLP_HEADER_WIDTH  TLP header
tx_data  output  DATA_WIDTH  payload (0 for MRd)
tx_sop  output  1  equals tx_valid (single-beat)
tx_eop  output  1  equals tx_valid (single-beat)
tx_ready  input  1  DLL accepts TLP when tx_valid&&tx_ready
rx_valid  input  1  TLP valid from DLL
rx_header  input  TLP_HEADER_WIDTH  received header
rx_data  input  DATA_WIDTH  received payload
rx_sop  input  1  start of TLP; only the sop beat is decoded
rx_eop  input  1  end of TLP (ignored)
rsp_valid  output  1  one-cycle response pulse; no backpressure
rsp_tag  output  10  tag of the response
rsp_data  output  DATA_WIDTH  completion payload (0 on timeout)
rsp_status  output  2  00=OK, 01=poisoned (EP=1), 10=timeout
err_unexp_cpl  output  1  one-cycle pulse for an unmatched completion
outstanding  output  $clog2(NUM_TAGS+1)  number of tags in use

Behaviour:
- Reset values (asynchronous): all outputs 0, all tags free, all timers 0, FSM=IDLE. Reset mid-operation drops in-flight TLPs and tags silently, with no rsp.
- Header layout: fmt[127:125], type[124:120], tc[119:117], ln[116], th[115], attr[2]=[114], at[113:112], attr[1:0]=[111:110], td[109], ep[108], length[107:98], requester_id[97:82], tag[9:8]=[81:80], tag[7:0]=[79:72], last_be[71:68], first_be[67:64], addr[63:0].
- TX fields: MWr fmt=010 type=00000; MRd fmt=000 type=00000; length=8; BEs=F/F; tc/attr/at/td/ep/ln/th=0; requester_id=REQ_ID; MWr tag=0.
- FSM IDLE -> SEND on command accept.
  - cmd_ready = (state==IDLE) && (cmd_write || free tag exists).
  - Read accept allocates the lowest free tag, starts its timer at 0 and increments outstanding.
- Latency: command accepted at edge N gives tx_valid=1 from cycle N+1.
- SEND: tx_valid/header/data held stable until tx_ready=1 at an edge, then return to IDLE with tx_valid=0. Back-to-back throughput is one TLP per 2 cycles.
- Completion decode: rx_valid && rx_sop && fmt=010 && type=01010.
  - If tag<NUM_TAGS and that tag is outstanding: at the next edge, rsp_valid=1 with rsp_tag, rsp_data=rx_data and status OK, or poisoned if ep=1. The tag is freed and outstanding decrements. The freed tag is allocatable from the following cycle.
  - Otherwise (unknown tag, free tag, or tag[9:8]!=0): err_unexp_cpl pulses one cycle later and the TLP is dropped.
  - Non-CplD TLPs are ignored.
- Timeout: each outstanding tag's timer increments per cycle.
  - When the timer reaches TIMEOUT_CYCLES-1, the tag is marked expired.
  - Expired tags are reported one per cycle, lowest index first: rsp_status=10, rsp_data=0, tag freed.
- Simultaneous events:
  - A completion and a timeout report in the same cycle: the completion wins and the timeout report defers one cycle.
  - A completion for a tag that is expired but not yet reported is delivered as a completion, and the timeout is cancelled.
  - Tag free and tag allocate in the same cycle: allocation considers pre-free state only.
- outstanding never exceeds NUM_TAGS. With all tags in use, cmd_ready=0 for reads while writes still proceed.

Test Plan:
- MWr addr=0x10 data=0xA5.. with tx_ready=1 -> tx_valid one cycle after accept, header[127:120]=0x40, length=8, addr=0x10, tx_data=0xA5..; no rsp.
- MRd addr=0x20 (tag 0) then CplD tag 0, ep=0, data=0x1234 -> rsp_valid one cycle after rx, rsp_tag=0, status=00, rsp_data=0x1234, outstanding 1->0.
- Issue 8 MRd with no completions -> tags 0..7 used, outstanding=8, cmd_ready=0 for a read and 1 for a write; CplD tag 3 -> next read gets tag 3.
- MRd with no completion -> rsp_status=10, rsp_tag=0 TIMEOUT_CYCLES cycles after accept; a later CplD tag 0 -> err_unexp_cpl=1.
- tx_ready=0 for 5 cycles during SEND -> tx_valid and header held stable; accepted on cycle 6; cmd_ready=0 throughout.
- CplD ep=1 for an outstanding tag -> status=01; assert rst_n low with 3 tags outstanding -> outstanding=0, no rsp, tx_valid=0.

Source files
------------

// File: rtl/pcie_tl_requester.sv
// Root-complex transaction-layer requester: single-beat MRd/MWr TLP generation,
// per-tag read tracking, CplD matching and per-tag completion timeout.
module pcie_tl_requester #(
    parameter int          ADDR_WIDTH       = 64,
    parameter int          DATA_WIDTH       = 256,
    parameter int          TLP_HEADER_WIDTH = 128,
    parameter int          NUM_TAGS         = 8,
    parameter int          TIMEOUT_CYCLES   = 1024,
    parameter logic [15:0] REQ_ID           = 16'h0100
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [ADDR_WIDTH-1:0]           cmd_addr,
    input  logic [DATA_WIDTH-1:0]           cmd_data,
    output logic                            tx_valid,
    output logic [TLP_HEADER_WIDTH-1:0]     tx_header,
    output logic [DATA_WIDTH-1:0]           tx_data,
    output logic                            tx_sop,
    output logic                            tx_eop,
    input  logic                            tx_ready,
    input  logic                            rx_valid,
    input  logic [TLP_HEADER_WIDTH-1:0]     rx_header,
    input  logic [DATA_WIDTH-1:0]           rx_data,
    input  logic                            rx_sop,
    input  logic                            rx_eop,
    output logic                            rsp_valid,
    output logic [9:0]                      rsp_tag,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic [1:0]                      rsp_status,
    output logic                            err_unexp_cpl,
    output logic [$clog2(NUM_TAGS+1)-1:0]   outstanding
);

    localparam int TW  = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    localparam int CW  = $clog2(NUM_TAGS + 1);
    localparam int TMW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMW-1:0] TMAX = TMW'(TIMEOUT_CYCLES - 1);

    // state | meaning
    // IDLE  | ready for a command
    // SEND  | TLP presented on tx, waiting for tx_ready
    typedef enum logic {IDLE, SEND} state_e;

    state_e                        state_q;
    logic                          tx_valid_q;
    logic [TLP_HEADER_WIDTH-1:0]   tx_header_q;
    logic [DATA_WIDTH-1:0]         tx_data_q;

    logic [NUM_TAGS-1:0]           busy_q, busy_d;
    logic [TMW-1:0]                timer_q [NUM_TAGS];
    logic [TMW-1:0]                timer_d [NUM_TAGS];
    logic [CW-1:0]                 outstanding_q, outstanding_d;
    logic                          rsp_valid_q, rsp_valid_d;
    logic [9:0]                    rsp_tag_q, rsp_tag_d;
    logic [DATA_WIDTH-1:0]         rsp_data_q, rsp_data_d;
    logic [1:0]                    rsp_status_q, rsp_status_d;
    logic                          err_unexp_q, err_unexp_d;

    logic                          free_found, exp_found;
    logic [TW-1:0]                 free_idx, exp_idx;
    logic [9:0]                    rx_tag;
    logic [TW-1:0]                 rx_tag_idx;
    logic                          rx_is_cpld, cpl_hit;
    logic                          cmd_acc, rd_alloc, freed;
    logic                          unused_rx;

    function automatic logic [TLP_HEADER_WIDTH-1:0] build_hdr(input logic wr,
                                                              input logic [TW-1:0] tag,
                                                              input logic [ADDR_WIDTH-1:0] addr);
        logic [TLP_HEADER_WIDTH-1:0] h;
        h            = '0;
        h[127:125]   = wr ? 3'b010 : 3'b000;
        h[107:98]    = 10'd8;
        h[97:82]     = REQ_ID;
        h[79:72]     = wr ? 8'd0 : 8'(tag);
        h[71:64]     = 8'hFF;
        h[63:0]      = 64'(addr);
        return h;
    endfunction

    // Lowest free tag and lowest expired tag, both from the registered table.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        exp_found  = 1'b0;
        exp_idx    = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = TW'(i);
            end
            if (busy_q[i] && timer_q[i] == TMAX) begin
                exp_found = 1'b1;
                exp_idx   = TW'(i);
            end
        end
    end

    assign rx_tag     = {rx_header[81:80], rx_header[79:72]};
    assign rx_tag_idx = rx_tag[TW-1:0];
    assign rx_is_cpld = rx_valid && rx_sop && (rx_header[127:125] == 3'b010) &&
                        (rx_header[124:120] == 5'b01010);
    assign cpl_hit    = rx_is_cpld && (rx_tag < 10'(NUM_TAGS)) && busy_q[rx_tag_idx];
    assign unused_rx  = ^{rx_eop, rx_header};

    assign cmd_ready = rst_n && (state_q == IDLE) && (cmd_write || free_found);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign rd_alloc  = cmd_acc && !cmd_write;

    // A completion takes the response slot; a pending timeout waits a cycle.
    always_comb begin
        busy_d       = busy_q;
        timer_d      = timer_q;
        rsp_valid_d  = 1'b0;
        rsp_tag_d    = '0;
        rsp_data_d   = '0;
        rsp_status_d = 2'b00;
        freed        = 1'b0;
        err_unexp_d  = rx_is_cpld && !cpl_hit;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (busy_q[i] && timer_q[i] != TMAX)
                timer_d[i] = timer_q[i] + TMW'(1);
        end
        if (cpl_hit) begin
            busy_d[rx_tag_idx] = 1'b0;
            rsp_valid_d        = 1'b1;
            rsp_tag_d          = rx_tag;
            rsp_data_d         = rx_data;
            rsp_status_d       = rx_header[108] ? 2'b01 : 2'b00;
            freed              = 1'b1;
        end else if (exp_found) begin
            busy_d[exp_idx] = 1'b0;
            rsp_valid_d     = 1'b1;
            rsp_tag_d       = 10'(exp_idx);
            rsp_status_d    = 2'b10;
            freed           = 1'b1;
        end
        if (rd_alloc) begin
            busy_d[free_idx]  = 1'b1;
            timer_d[free_idx] = '0;
        end
        case ({rd_alloc, freed})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= '0;
            outstanding_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_tag_q     <= '0;
            rsp_data_q    <= '0;
            rsp_status_q  <= 2'b00;
            err_unexp_q   <= 1'b0;
            for (int i = 0; i < NUM_TAGS; i++) timer_q[i] <= '0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_data_q    <= rsp_data_d;
            rsp_status_q  <= rsp_status_d;
            err_unexp_q   <= err_unexp_d;
            for (int i = 0; i < NUM_TAGS; i++) timer_q[i] <= timer_d[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_valid_q  <= 1'b0;
            tx_header_q <= '0;
            tx_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (cmd_acc) begin
                    state_q     <= SEND;
                    tx_valid_q  <= 1'b1;
                    tx_header_q <= build_hdr(cmd_write, free_idx, cmd_addr);
                    tx_data_q   <= cmd_write ? cmd_data : '0;
                end
                SEND: if (tx_ready) begin
                    state_q     <= IDLE;
                    tx_valid_q  <= 1'b0;
                    tx_header_q <= '0;
                    tx_data_q   <= '0;
                end
            endcase
        end
    end

    assign tx_valid      = tx_valid_q;
    assign tx_header     = tx_header_q;
    assign tx_data       = tx_data_q;
    assign tx_sop        = tx_valid_q;
    assign tx_eop        = tx_valid_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_tag       = rsp_tag_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_status    = rsp_status_q;
    assign err_unexp_cpl = err_unexp_q;
    assign outstanding   = outstanding_q;

endmodule

// File: tb/tb_pcie_tl_requester.sv
// Bench for pcie_tl_requester: vector table plus corner sequences, with
// scoreboard queues for outgoing TLPs and application responses.
module tb_pcie_tl_requester;

    localparam int T = 128;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_write = 1'b0;
    logic [63:0]  cmd_addr = '0;
    logic [255:0] cmd_data = '0;
    logic         tx_valid;
    logic [127:0] tx_header;
    logic [255:0] tx_data;
    logic         tx_sop, tx_eop;
    logic         tx_ready = 1'b1;
    logic         rx_valid = 1'b0;
    logic [127:0] rx_header = '0;
    logic [255:0] rx_data = '0;
    logic         rx_sop = 1'b0;
    logic         rx_eop = 1'b0;
    logic         rsp_valid;
    logic [9:0]   rsp_tag;
    logic [255:0] rsp_data;
    logic [1:0]   rsp_status;
    logic         err_unexp_cpl;
    logic [3:0]   outstanding;

    pcie_tl_requester #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .tx_valid(tx_valid), .tx_header(tx_header), .tx_data(tx_data),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_header(rx_header), .rx_data(rx_data),
        .rx_sop(rx_sop), .rx_eop(rx_eop),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .err_unexp_cpl(err_unexp_cpl),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct { logic [127:0] hdr; logic [255:0] data; } tx_exp_t;
    typedef struct { logic [9:0] tag; logic [255:0] data; logic [1:0] status; } rsp_exp_t;
    typedef struct {
        logic wr; logic [63:0] addr; logic [255:0] data;
        logic ep; logic [255:0] cdata; logic [1:0] status; logic [7:0] ft;
    } vec_t;

    tx_exp_t  tx_q[$];
    rsp_exp_t rsp_q[$];
    tx_exp_t  mon_tx;
    rsp_exp_t mon_rsp;
    vec_t     vec[5];
    int       n_pass = 0;
    int       n_total = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] exp_hdr(input logic wr, input int tag, input logic [63:0] addr);
        logic [127:0] h;
        h          = '0;
        h[127:125] = wr ? 3'b010 : 3'b000;
        h[107:98]  = 10'd8;
        h[97:82]   = 16'h0100;
        h[81:72]   = wr ? 10'd0 : 10'(tag);
        h[71:64]   = 8'hFF;
        h[63:0]    = addr;
        return h;
    endfunction

    // Scoreboard side: compare every TLP handed to the DLL and every response.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) chk("tx_unexpected", 256'(tx_valid), 256'd0);
                else begin
                    mon_tx = tx_q.pop_front();
                    chk("tx_header", 256'(tx_header), 256'(mon_tx.hdr));
                    chk("tx_data", tx_data, mon_tx.data);
                    chk("tx_sop_eop", 256'({tx_sop, tx_eop}), 256'(2'b11));
                end
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) chk("rsp_unexpected", 256'(rsp_valid), 256'd0);
                else begin
                    mon_rsp = rsp_q.pop_front();
                    chk("rsp_tag", 256'(rsp_tag), 256'(mon_rsp.tag));
                    chk("rsp_data", rsp_data, mon_rsp.data);
                    chk("rsp_status", 256'(rsp_status), 256'(mon_rsp.status));
                end
            end
        end
    end

    // All tasks start and end just after a rising edge.
    task automatic issue(input logic wr, input logic [63:0] addr, input logic [255:0] data,
                         input int tag, input logic [7:0] ft);
        tx_exp_t e;
        int      k;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_data = data;
        #1;
        k = 0;
        while (!cmd_ready && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", 256'(cmd_ready), 256'd1);
            cmd_valid = 1'b0;
            return;
        end
        e.hdr  = exp_hdr(wr, tag, addr);
        e.data = wr ? data : '0;
        tx_q.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("tx_latency", 256'(tx_valid), 256'd1);
        chk("hdr_fmt_type", 256'(tx_header[127:120]), 256'(ft));
    endtask

    task automatic send_cpl(input logic [7:0] ft, input logic [9:0] tag, input logic ep,
                            input logic [255:0] d, input logic [1:0] status, input logic hit);
        rsp_exp_t r;
        rx_valid = 1'b1; rx_sop = 1'b1; rx_eop = 1'b1;
        rx_header = '0;
        rx_header[127:120] = ft;
        rx_header[108]     = ep;
        rx_header[81:72]   = tag;
        rx_data = d;
        if (hit) begin
            r.tag = tag; r.data = d; r.status = status;
            rsp_q.push_back(r);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
        chk("cpl_rsp_valid", 256'(rsp_valid), 256'(hit));
        chk("err_unexp_cpl", 256'(err_unexp_cpl), 256'((ft == 8'h4A) && !hit));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        vec[0] = '{1'b1, 64'h10, {32{8'hA5}}, 1'b0, 256'd0, 2'b00, 8'h40};
        vec[1] = '{1'b0, 64'h20, 256'd0, 1'b0, 256'h1234, 2'b00, 8'h00};
        vec[2] = '{1'b0, 64'hDEAD_BEEF_0000_0040, 256'd0, 1'b1, {8{32'h0BAD_F00D}}, 2'b01, 8'h00};
        vec[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, {16{16'h5A3C}}, 1'b0, 256'd0, 2'b00, 8'h40};
        vec[4] = '{1'b0, 64'h0, 256'd0, 1'b0, {256{1'b1}}, 2'b00, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 256'(tx_valid), 256'd0);
        chk("rst_rsp_valid", 256'(rsp_valid), 256'd0);
        chk("rst_outstanding", 256'(outstanding), 256'd0);
        chk("rst_err", 256'(err_unexp_cpl), 256'd0);
        chk("rst_cmd_ready", 256'(cmd_ready), 256'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_cmd_ready", 256'(cmd_ready), 256'd1);

        for (int i = 0; i < 5; i++) begin
            issue(vec[i].wr, vec[i].addr, vec[i].data, 0, vec[i].ft);
            chk("hdr_length", 256'(tx_header[107:98]), 256'd8);
            @(posedge clk); #1;
            if (!vec[i].wr) begin
                chk("outstanding_one", 256'(outstanding), 256'd1);
                send_cpl(8'h4A, 10'd0, vec[i].ep, vec[i].cdata, vec[i].status, 1'b1);
                chk("outstanding_zero", 256'(outstanding), 256'd0);
            end
        end

        // Fill all tags, then check read/write readiness and tag reuse.
        for (int t = 0; t < 8; t++) issue(1'b0, 64'h1000 + 64'(t * 64), '0, t, 8'h00);
        chk("outstanding_full", 256'(outstanding), 256'd8);
        @(posedge clk); #1;
        cmd_write = 1'b0; #1;
        chk("full_rd_ready", 256'(cmd_ready), 256'd0);
        cmd_write = 1'b1; #1;
        chk("full_wr_ready", 256'(cmd_ready), 256'd1);
        issue(1'b1, 64'h2000, {8{32'hCAFE_F00D}}, 0, 8'h40);
        @(posedge clk); #1;
        send_cpl(8'h4A, 10'd3, 1'b0, 256'h3333, 2'b00, 1'b1);
        chk("outstanding_seven", 256'(outstanding), 256'd7);
        issue(1'b0, 64'h3000, '0, 3, 8'h00);
        chk("realloc_tag", 256'(tx_header[81:72]), 256'd3);
        @(posedge clk); #1;
        for (int t = 0; t < 8; t++) send_cpl(8'h4A, 10'(t), 1'b0, 256'(t + 100), 2'b00, 1'b1);
        chk("outstanding_drained", 256'(outstanding), 256'd0);

        // Timeout, then late / malformed / non-completion traffic.
        issue(1'b0, 64'h40, '0, 0, 8'h00);
        rsp_q.push_back('{10'd0, 256'd0, 2'b10});
        k = 0;
        while (k < T + 4) begin
            @(posedge clk); #1;
            k++;
            if (rsp_valid) break;
        end
        chk("timeout_latency", 256'(k), 256'(T));
        chk("timeout_freed", 256'(outstanding), 256'd0);
        @(posedge clk); #1;
        send_cpl(8'h4A, 10'd0, 1'b0, 256'h55, 2'b00, 1'b0);
        send_cpl(8'h4A, 10'h100, 1'b0, 256'h66, 2'b00, 1'b0);
        send_cpl(8'h40, 10'd0, 1'b0, 256'h77, 2'b00, 1'b0);

        // Completion lands while its tag is expired but not yet reported.
        issue(1'b0, 64'h80, '0, 0, 8'h00);
        repeat (T - 1) @(posedge clk);
        #1;
        send_cpl(8'h4A, 10'd0, 1'b0, 256'hBEEF, 2'b00, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("expired_cpl_outstanding", 256'(outstanding), 256'd0);

        // DLL backpressure: TLP held stable for five cycles.
        tx_ready = 1'b0;
        issue(1'b1, 64'hC0, {4{64'h0123_4567_89AB_CDEF}}, 0, 8'h40);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 256'(tx_valid), 256'd1);
            chk("hold_header", 256'(tx_header), 256'(exp_hdr(1'b1, 0, 64'hC0)));
            chk("hold_cmd_ready", 256'(cmd_ready), 256'd0);
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_released", 256'(tx_valid), 256'd0);

        // Reset with three reads outstanding and one TLP stuck in SEND.
        issue(1'b0, 64'h100, '0, 0, 8'h00);
        @(posedge clk); #1;
        issue(1'b0, 64'h140, '0, 1, 8'h00);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        issue(1'b0, 64'h180, '0, 2, 8'h00);
        chk("pre_reset_outstanding", 256'(outstanding), 256'd3);
        rst_n = 1'b0;
        #1;
        chk("reset_outstanding", 256'(outstanding), 256'd0);
        chk("reset_tx_valid", 256'(tx_valid), 256'd0);
        chk("reset_rsp_valid", 256'(rsp_valid), 256'd0);
        chk("tx_pending_dropped", 256'(tx_q.size()), 256'd1);
        tx_q.delete();
        tx_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (T + 10) @(posedge clk);
        #1;
        chk("post_reset_outstanding", 256'(outstanding), 256'd0);
        issue(1'b0, 64'h200, '0, 0, 8'h00);
        @(posedge clk); #1;
        send_cpl(8'h4A, 10'd0, 1'b0, 256'hABCD, 2'b00, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("tx_queue_empty", 256'(tx_q.size()), 256'd0);
        chk("rsp_queue_empty", 256'(rsp_q.size()), 256'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
